// File: rtl/parking_pkg.sv
// Shared encodings for the parking entry-gate controller: FSM states,
// active-low seven-segment glyphs (bit6 = g) and the decimal digit table.
package parking_pkg;

    typedef logic [6:0] seg_t;

    localparam logic [2:0] ST_IDLE          = 3'd0;
    localparam logic [2:0] ST_WAIT_PASSWORD = 3'd1;
    localparam logic [2:0] ST_WRONG_PASS    = 3'd2;
    localparam logic [2:0] ST_RIGHT_PASS    = 3'd3;
    localparam logic [2:0] ST_STOP          = 3'd4;
    localparam logic [2:0] ST_FULL          = 3'd5;
    localparam logic [2:0] ST_LOCKOUT       = 3'd6;

    localparam seg_t SEG_E   = 7'h06;
    localparam seg_t SEG_N   = 7'h2B;
    localparam seg_t SEG_6   = 7'h02;
    localparam seg_t SEG_0   = 7'h40;
    localparam seg_t SEG_5   = 7'h12;
    localparam seg_t SEG_P   = 7'h0C;
    localparam seg_t SEG_F   = 7'h0E;
    localparam seg_t SEG_L   = 7'h47;
    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t DIGIT_GLYPH [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/seg7_digit.sv
// Decimal digit to active-low seven-segment decoder; only elaborated when
// OCC_DISPLAY_EN is defined, since nothing else uses it.
`ifdef OCC_DISPLAY_EN
module seg7_digit
    import parking_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Values above 9 blank the digit rather than index past the table
    always_comb begin
        if (digit <= 4'd9) begin
            seg = DIGIT_GLYPH[digit];
        end else begin
            seg = SEG_OFF;
        end
    end

endmodule
`endif

// File: rtl/parking_gate_ctrl.sv
// Car-park entry-gate controller: capacity tracking, password check with
// lockout and timeout, blinking LEDs. OCC_DISPLAY_EN shows occupancy in IDLE.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int              CAPACITY       = 8,
    parameter int              PW_W           = 2,
    parameter logic [PW_W-1:0] PASS_1         = 2'b01,
    parameter logic [PW_W-1:0] PASS_2         = 2'b10,
    parameter int              WAIT_CYCLES    = 4,
    parameter int              TIMEOUT_CYCLES = 32,
    parameter int              MAX_TRIES      = 3,
    parameter int              LOCK_CYCLES    = 16,
    parameter int              BLINK_DIV      = 2,
    localparam int             CNT_W          = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_entrance,
    input  logic             sensor_exit,
    input  logic             car_depart,
    input  logic [PW_W-1:0]  password_1,
    input  logic [PW_W-1:0]  password_2,
    input  logic             pass_valid,
    output logic             GREEN_LED,
    output logic             RED_LED,
    output logic [6:0]       HEX_1,
    output logic [6:0]       HEX_2,
    output logic [CNT_W-1:0] occupancy,
    output logic             full
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int BLK_W  = $clog2(BLINK_DIV + 1);

    logic [2:0]        state_r;
    logic [2:0]        next_state_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [LOCK_W-1:0] lock_cnt_r;
    logic [TRY_W-1:0]  tries_r;
    logic [TRY_W-1:0]  next_tries_s;
    logic [BLK_W-1:0]  blink_cnt_r;
    logic              blink_r;
    logic [CNT_W-1:0]  occ_r;
    logic              match_s;
    logic              miss_s;
    logic              accept_s;
    logic              full_s;
    logic              inc_s;
    logic              dec_s;
    logic              green_s;
    logic              red_s;
    seg_t              hex1_s;
    seg_t              hex2_s;
    seg_t              idle_hex1_s;
    seg_t              idle_hex2_s;

    assign match_s   = pass_valid && (password_1 == PASS_1) && (password_2 == PASS_2);
    assign miss_s    = pass_valid && !match_s;
    assign accept_s  = (wait_cnt_r >= WAIT_W'(WAIT_CYCLES));
    assign full_s    = (occ_r == CNT_W'(CAPACITY));
    assign inc_s     = (state_r == ST_RIGHT_PASS) && sensor_exit && !sensor_entrance;
    assign dec_s     = car_depart;
    assign full      = full_s;
    assign occupancy = occ_r;

    // Next-state and wrong-attempt bookkeeping
    always_comb begin
        next_state_s = state_r;
        next_tries_s = tries_r;
        case (state_r)
            ST_IDLE: begin
                if (sensor_entrance && full_s) begin
                    next_state_s = ST_FULL;
                end else if (sensor_entrance) begin
                    next_state_s = ST_WAIT_PASSWORD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_PASSWORD: begin
                if (accept_s && match_s) begin
                    next_state_s = ST_RIGHT_PASS;
                    next_tries_s = {TRY_W{1'b0}};
                end else if (accept_s && miss_s) begin
                    next_tries_s = TRY_W'(1);
                    if (MAX_TRIES <= 1) begin
                        next_state_s = ST_LOCKOUT;
                    end else begin
                        next_state_s = ST_WRONG_PASS;
                    end
                end else if (wait_cnt_r == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT_PASSWORD;
                end
            end
            ST_WRONG_PASS: begin
                if (match_s) begin
                    next_state_s = ST_RIGHT_PASS;
                    next_tries_s = {TRY_W{1'b0}};
                end else if (miss_s) begin
                    next_tries_s = tries_r + TRY_W'(1);
                    if (tries_r >= TRY_W'(MAX_TRIES - 1)) begin
                        next_state_s = ST_LOCKOUT;
                    end else begin
                        next_state_s = ST_WRONG_PASS;
                    end
                end else begin
                    next_state_s = ST_WRONG_PASS;
                end
            end
            ST_RIGHT_PASS: begin
                if (sensor_entrance && sensor_exit) begin
                    next_state_s = ST_STOP;
                end else if (sensor_exit) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RIGHT_PASS;
                end
            end
            ST_STOP: begin
                // A wrong entry here is only a hold-up, not an attack attempt
                if (match_s) begin
                    next_state_s = ST_RIGHT_PASS;
                    next_tries_s = {TRY_W{1'b0}};
                end else begin
                    next_state_s = ST_STOP;
                end
            end
            ST_FULL: begin
                if (!sensor_entrance) begin
                    next_state_s = ST_IDLE;
                end else if (!full_s) begin
                    next_state_s = ST_WAIT_PASSWORD;
                end else begin
                    next_state_s = ST_FULL;
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt_r == LOCK_W'(LOCK_CYCLES - 1)) begin
                    next_state_s = ST_IDLE;
                    next_tries_s = {TRY_W{1'b0}};
                end else begin
                    next_state_s = ST_LOCKOUT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_tries_s = {TRY_W{1'b0}};
            end
        endcase
    end

    // State register plus per-state dwell counters and blink divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            tries_r     <= {TRY_W{1'b0}};
            wait_cnt_r  <= {WAIT_W{1'b0}};
            lock_cnt_r  <= {LOCK_W{1'b0}};
            blink_cnt_r <= {BLK_W{1'b0}};
            blink_r     <= 1'b1;
        end else begin
            state_r <= next_state_s;
            tries_r <= next_tries_s;
            if (next_state_s != state_r) begin
                wait_cnt_r  <= {WAIT_W{1'b0}};
                lock_cnt_r  <= {LOCK_W{1'b0}};
                blink_cnt_r <= {BLK_W{1'b0}};
                blink_r     <= 1'b1;
            end else begin
                if (state_r == ST_WAIT_PASSWORD) begin
                    wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                end else begin
                    wait_cnt_r <= wait_cnt_r;
                end
                if (state_r == ST_LOCKOUT) begin
                    lock_cnt_r <= lock_cnt_r + LOCK_W'(1);
                end else begin
                    lock_cnt_r <= lock_cnt_r;
                end
                if (blink_cnt_r == BLK_W'(BLINK_DIV - 1)) begin
                    blink_cnt_r <= {BLK_W{1'b0}};
                    blink_r     <= !blink_r;
                end else begin
                    blink_cnt_r <= blink_cnt_r + BLK_W'(1);
                    blink_r     <= blink_r;
                end
            end
        end
    end

    // Occupancy: saturating up on a completed entry, down on a departure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r <= {CNT_W{1'b0}};
        end else if (inc_s && !dec_s && !full_s) begin
            occ_r <= occ_r + CNT_W'(1);
        end else if (dec_s && !inc_s && (occ_r != {CNT_W{1'b0}})) begin
            occ_r <= occ_r - CNT_W'(1);
        end else begin
            occ_r <= occ_r;
        end
    end

`ifdef OCC_DISPLAY_EN
    logic [31:0] occ_ext_s;
    logic [3:0]  tens_s;
    logic [3:0]  units_s;

    assign occ_ext_s = 32'(occ_r);
    assign tens_s    = 4'(occ_ext_s / 32'd10);
    assign units_s   = 4'(occ_ext_s % 32'd10);

    seg7_digit u_tens  (.digit(tens_s),  .seg(idle_hex1_s));
    seg7_digit u_units (.digit(units_s), .seg(idle_hex2_s));
`else
    assign idle_hex1_s = SEG_OFF;
    assign idle_hex2_s = SEG_OFF;
`endif

    // Per-state indicator decode
    always_comb begin
        green_s = 1'b0;
        red_s   = 1'b0;
        hex1_s  = SEG_OFF;
        hex2_s  = SEG_OFF;
        case (state_r)
            ST_IDLE: begin
                hex1_s = idle_hex1_s;
                hex2_s = idle_hex2_s;
            end
            ST_WAIT_PASSWORD: begin
                red_s  = 1'b1;
                hex1_s = SEG_E;
                hex2_s = SEG_N;
            end
            ST_WRONG_PASS: begin
                red_s  = blink_r;
                hex1_s = SEG_E;
                hex2_s = SEG_E;
            end
            ST_RIGHT_PASS: begin
                green_s = blink_r;
                hex1_s  = SEG_6;
                hex2_s  = SEG_0;
            end
            ST_STOP: begin
                red_s  = blink_r;
                hex1_s = SEG_5;
                hex2_s = SEG_P;
            end
            ST_FULL: begin
                red_s  = 1'b1;
                hex1_s = SEG_F;
                hex2_s = SEG_L;
            end
            ST_LOCKOUT: begin
                red_s  = 1'b1;
                hex1_s = SEG_L;
                hex2_s = SEG_0;
            end
            default: begin
                red_s  = 1'b1;
                hex1_s = SEG_OFF;
                hex2_s = SEG_OFF;
            end
        endcase
    end

    // Registered Moore outputs, one cycle behind the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            GREEN_LED <= 1'b0;
            RED_LED   <= 1'b0;
            HEX_1     <= SEG_OFF;
            HEX_2     <= SEG_OFF;
        end else begin
            GREEN_LED <= green_s;
            RED_LED   <= red_s;
            HEX_1     <= hex1_s;
            HEX_2     <= hex2_s;
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed scenarios then random
// stimulus, all compared cycle by cycle against a time-in-state reference model.
module tb_parking_gate_ctrl;

    localparam int CAP   = 8;
    localparam int WAITC = 4;
    localparam int TOUT  = 32;
    localparam int MAXT  = 3;
    localparam int LOCKC = 16;
    localparam int BDIV  = 2;

    typedef enum int {M_IDLE, M_WAIT, M_WRONG, M_RIGHT, M_STOP, M_FULL, M_LOCK} mstate_e;

    logic       clk;
    logic       rst_n;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic       car_depart;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       pass_valid;
    logic       GREEN_LED;
    logic       RED_LED;
    logic [6:0] HEX_1;
    logic [6:0] HEX_2;
    logic [3:0] occupancy;
    logic       full;

    int      checks_cnt;
    int      errors_cnt;
    mstate_e m_state;
    int      m_t;
    int      m_tries;
    int      m_occ;
    logic [6:0] digits [0:9];

    parking_gate_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sensor_entrance(sensor_entrance),
        .sensor_exit    (sensor_exit),
        .car_depart     (car_depart),
        .password_1     (password_1),
        .password_2     (password_2),
        .pass_valid     (pass_valid),
        .GREEN_LED      (GREEN_LED),
        .RED_LED        (RED_LED),
        .HEX_1          (HEX_1),
        .HEX_2          (HEX_2),
        .occupancy      (occupancy),
        .full           (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Indicator values the gate should show for a model state and dwell time
    task automatic model_outputs(output logic g, output logic r, output logic [6:0] h1, output logic [6:0] h2);
        logic blink;
        blink = ((m_t / BDIV) % 2) == 0;
        g = 1'b0; r = 1'b0; h1 = 7'h7F; h2 = 7'h7F;
        case (m_state)
            M_IDLE: begin
`ifdef OCC_DISPLAY_EN
                h1 = digits[m_occ / 10];
                h2 = digits[m_occ % 10];
`endif
            end
            M_WAIT:  begin r = 1'b1;  h1 = 7'h06; h2 = 7'h2B; end
            M_WRONG: begin r = blink; h1 = 7'h06; h2 = 7'h06; end
            M_RIGHT: begin g = blink; h1 = 7'h02; h2 = 7'h40; end
            M_STOP:  begin r = blink; h1 = 7'h12; h2 = 7'h0C; end
            M_FULL:  begin r = 1'b1;  h1 = 7'h0E; h2 = 7'h47; end
            M_LOCK:  begin r = 1'b1;  h1 = 7'h47; h2 = 7'h40; end
            default: begin r = 1'b1; end
        endcase
    endtask

    task automatic model_step(input logic ent, input logic ex, input logic dep, input logic pv,
                              input logic [1:0] p1, input logic [1:0] p2);
        bit      mt, ms, inc;
        mstate_e nxt;
        mt  = pv && (p1 == 2'b01) && (p2 == 2'b10);
        ms  = pv && !mt;
        inc = 1'b0;
        nxt = m_state;
        case (m_state)
            M_IDLE:  if (ent) nxt = (m_occ == CAP) ? M_FULL : M_WAIT;
            M_WAIT: begin
                if (m_t >= WAITC && mt) begin nxt = M_RIGHT; m_tries = 0; end
                else if (m_t >= WAITC && ms) begin m_tries = 1; nxt = (m_tries >= MAXT) ? M_LOCK : M_WRONG; end
                else if (m_t == TOUT - 1) nxt = M_IDLE;
            end
            M_WRONG: begin
                if (mt) begin nxt = M_RIGHT; m_tries = 0; end
                else if (ms) begin m_tries++; if (m_tries >= MAXT) nxt = M_LOCK; end
            end
            M_RIGHT: begin
                if (ent && ex) nxt = M_STOP;
                else if (ex) begin nxt = M_IDLE; inc = 1'b1; end
            end
            M_STOP:  if (mt) begin nxt = M_RIGHT; m_tries = 0; end
            M_FULL: begin
                if (!ent) nxt = M_IDLE;
                else if (m_occ != CAP) nxt = M_WAIT;
            end
            M_LOCK:  if (m_t == LOCKC - 1) begin nxt = M_IDLE; m_tries = 0; end
            default: nxt = M_IDLE;
        endcase
        if (inc && !dep && m_occ < CAP) m_occ++;
        else if (dep && !inc && m_occ > 0) m_occ--;
        m_t     = (nxt == m_state) ? m_t + 1 : 0;
        m_state = nxt;
    endtask

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic cyc(input logic ent, input logic ex, input logic dep, input logic pv,
                       input logic [1:0] p1, input logic [1:0] p2);
        logic       eg, er;
        logic [6:0] eh1, eh2;
        sensor_entrance = ent; sensor_exit = ex; car_depart = dep;
        pass_valid = pv; password_1 = p1; password_2 = p2;
        model_outputs(eg, er, eh1, eh2);
        model_step(ent, ex, dep, pv, p1, p2);
        @(posedge clk);
        #1;
        check_val("green", 32'(GREEN_LED), 32'(eg));
        check_val("red", 32'(RED_LED), 32'(er));
        check_val("hex1", 32'(HEX_1), 32'(eh1));
        check_val("hex2", 32'(HEX_2), 32'(eh2));
        check_val("occupancy", 32'(occupancy), 32'(m_occ));
        check_val("full", 32'(full), 32'(m_occ == CAP));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic enter_car();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        idle_cycles(WAITC);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic apply_reset();
        sensor_entrance = 1'b0; sensor_exit = 1'b0; car_depart = 1'b0;
        pass_valid = 1'b0; password_1 = 2'b00; password_2 = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        m_state = M_IDLE; m_t = 0; m_tries = 0; m_occ = 0;
        check_val("rst_green", 32'(GREEN_LED), 32'd0);
        check_val("rst_red", 32'(RED_LED), 32'd0);
        check_val("rst_hex1", 32'(HEX_1), 32'h7F);
        check_val("rst_hex2", 32'(HEX_2), 32'h7F);
        check_val("rst_occ", 32'(occupancy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] p1, p2;
        logic       pv;
        checks_cnt = 0; errors_cnt = 0;
        digits[0] = 7'h40; digits[1] = 7'h79; digits[2] = 7'h24; digits[3] = 7'h30; digits[4] = 7'h19;
        digits[5] = 7'h12; digits[6] = 7'h02; digits[7] = 7'h78; digits[8] = 7'h00; digits[9] = 7'h10;
        rst_n = 1'b1;
        #3;
        apply_reset();

        // Early strobe ignored, strobe at the fourth waiting cycle accepted
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        idle_cycles(2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10);
        idle_cycles(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10);
        idle_cycles(8);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);

        // Three wrong entries, ignored correct entry during lockout
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        idle_cycles(WAITC);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10);
        idle_cycles(LOCKC + 2);

        // Fill the lot, then FULL and release by a departure
        while (m_occ < CAP) enter_car();
        check_val("occ_at_capacity", 32'(occupancy), 32'd8);
        check_val("full_at_capacity", 32'(full), 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        check_val("occ_after_depart", 32'(occupancy), 32'd7);
        check_val("full_after_depart", 32'(full), 32'd0);

        // STOP: wrong strobe held there without counting, correct strobe resumes
        idle_cycles(WAITC);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b01);
        check_val("tries_in_stop", 32'(m_tries), 32'd0);
        idle_cycles(3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10);
        idle_cycles(2);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);

        // Timeout with no entry, then drain below zero
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        idle_cycles(TOUT + 3);
        for (int i = 0; i < CAP + 2; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        check_val("occ_floor", 32'(occupancy), 32'd0);

        // Occupancy 5 for the idle display, then reset in the middle of LOCKOUT
        for (int i = 0; i < 5; i++) enter_car();
        idle_cycles(2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        idle_cycles(WAITC);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        idle_cycles(5);
        apply_reset();
        idle_cycles(2);

        // Random traffic with a bias towards valid passwords
        for (int i = 0; i < 4000; i++) begin
            pv = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 1) == 0) begin
                p1 = 2'b01; p2 = 2'b10;
            end else begin
                p1 = 2'($urandom_range(0, 3)); p2 = 2'($urandom_range(0, 3));
            end
            cyc($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 8, pv, p1, p2);
        end

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
Parametrised entry-gate controller for the car park, and the successor to the single-gate password FSM. It adds capacity tracking with a FULL state, a configurable password width, an explicit password-valid strobe, a wrong-attempt lockout, a wait timeout and a divided LED blink rate. It sits between the gate sensors, keypad and display/LED pins; outputs are registered Moore-style.

Parameters:
CAPACITY, 8, number of parking slots
PW_W, 2, width of each password field
PASS_1, 2'b01, expected password_1
PASS_2, 2'b10, expected password_2
WAIT_CYCLES, 4, cycles in WAIT_PASSWORD before pass_valid is accepted
TIMEOUT_CYCLES, 32, cycles in WAIT_PASSWORD without accepted entry before returning to IDLE (> WAIT_CYCLES)
MAX_TRIES, 3, consecutive wrong entries that trigger LOCKOUT
LOCK_CYCLES, 16, LOCKOUT duration
BLINK_DIV, 2, cycles per LED blink half-period (>=1)
Derived: CNT_W = $clog2(CAPACITY+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sensor_entrance  in  1  car present at entrance
sensor_exit  in  1  car passed through gate
car_depart  in  1  one-cycle pulse: a car left the lot
password_1  in  PW_W  keypad field 1
password_2  in  PW_W  keypad field 2
pass_valid  in  1  one-cycle strobe: password fields valid
GREEN_LED  out  1  gate open indicator
RED_LED  out  1  stop/error indicator
HEX_1  out  7  seven-segment digit 1, active-low, bit6=g
HEX_2  out  7  seven-segment digit 2, active-low, bit6=g
occupancy  out  CNT_W  cars currently parked
full  out  1  occupancy == CAPACITY

Behaviour:
- Reset (async, rst_n=0): state IDLE, all counters 0, occupancy 0, LEDs 0, HEX_1/HEX_2 7'h7F.
- States: IDLE, WAIT_PASSWORD, WRONG_PASS, RIGHT_PASS, STOP, FULL, LOCKOUT (3-bit).
- match = pass_valid && password_1==PASS_1 && password_2==PASS_2; miss = pass_valid && !match.
- IDLE: sensor_entrance && !full -> WAIT_PASSWORD; sensor_entrance && full -> FULL.
- WAIT_PASSWORD: wait_cnt counts from 0 on entry. pass_valid is ignored while wait_cnt < WAIT_CYCLES. After that, match -> RIGHT_PASS; miss -> WRONG_PASS with tries=1 (LOCKOUT if MAX_TRIES==1). wait_cnt == TIMEOUT_CYCLES-1 with no accepted entry -> IDLE.
- WRONG_PASS: match -> RIGHT_PASS and tries cleared. On miss, tries++; if tries reaches MAX_TRIES -> LOCKOUT.
- LOCKOUT: all inputs except car_depart are ignored; after LOCK_CYCLES cycles -> IDLE, tries cleared.
- RIGHT_PASS: sensor_entrance && sensor_exit -> STOP; sensor_exit alone -> IDLE and occupancy+1, saturating at CAPACITY. Tries cleared on entry.
- STOP: match -> RIGHT_PASS; miss is ignored and does not count toward tries.
- FULL: !sensor_entrance -> IDLE; sensor_entrance && !full -> WAIT_PASSWORD.
- car_depart decrements occupancy in any state, saturating at 0. If increment and decrement occur in the same cycle, occupancy is unchanged.
- Outputs are registered from current_state, so they lag the state by one cycle.
  - Blink phase divider restarts on every state change; phase starts at 1 and toggles every BLINK_DIV cycles.
- Per-state outputs (GREEN, RED, HEX_1, HEX_2):
  - IDLE: 0, 0, 7F, 7F
  - WAIT_PASSWORD: 0, 1, 06 "E", 2B "n"
  - WRONG_PASS: 0, blink, 06, 06
  - RIGHT_PASS: blink, 0, 02 "6", 40 "0"
  - STOP: 0, blink, 12 "5", 0C "P"
  - FULL: 0, 1, 0E "F", 47 "L"
  - LOCKOUT: 0, 1, 47 "L", 40 "0"
- full is combinational from occupancy.

Optional Feature:
OCC_DISPLAY_EN: when defined, IDLE drives HEX_1/HEX_2 with the occupancy as two decimal digits (tens, units; leading zero shown). When undefined, IDLE displays 7F/7F. Other states are unaffected either way.

Decomposition:
- Package parking_pkg: state encodings, seven-segment glyph constants (E, n, 6, 0, 5, P, F, L, off), digit glyph table 0-9.
- One sub-module, seg7_digit: a 4-bit to 7-bit active-low decoder, instantiated twice only under OCC_DISPLAY_EN.

Test Plan:
- Reset, then sensor_entrance=1; pass_valid with 01/10 at wait_cnt=2 -> ignored; repeat at wait_cnt=4 -> RIGHT_PASS, GREEN toggles every 2 cycles, HEX 02/40.
- Three consecutive wrong strobes (11/11) -> WRONG_PASS then LOCKOUT; a correct password during LOCKOUT is ignored; IDLE after 16 cycles.
- Eight complete entries (RIGHT_PASS then sensor_exit) -> occupancy=8, full=1; next sensor_entrance -> FULL, HEX 0E/47; car_depart with entrance held -> WAIT_PASSWORD, occupancy=7.
- In RIGHT_PASS, entrance and exit together -> STOP; wrong strobe keeps STOP and tries=0; correct strobe -> RIGHT_PASS.
- Enter WAIT_PASSWORD with no pass_valid -> IDLE after 32 cycles; car_depart at occupancy=0 -> stays 0; simultaneous entry and depart -> unchanged.
- Assert rst_n=0 mid-LOCKOUT -> immediate IDLE, occupancy 0, HEX 7F/7F; with OCC_DISPLAY_EN, occupancy=5 in IDLE -> HEX 40/12.
